// File: rtl/flash_prog.sv
// flash_prog: Wishbone B3 classic slave that byte-programs an AMD-style parallel NOR flash.
// Each write runs the unlock/program command sequence and a DQ7 poll per selected lane.
module flash_prog #(
  parameter int unsigned WP = 3,
  parameter int unsigned PS = 3,
  parameter logic [15:0] TO = 16'd4000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [21:0] flash_adr_o,
  output logic [7:0]  flash_dat_o,
  input  logic [7:0]  flash_dat_i,
  output logic        flash_dat_oe,
  output logic        flash_ce,
  output logic        flash_we,
  output logic        flash_oe,
  output logic        flash_rst
);
  localparam logic [3:0] WP_C = 4'(WP);
  localparam logic [3:0] PS_C = 4'(PS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_POLL  = 3'd5,
    S_GAP   = 3'd6,
    S_ACK   = 3'd7
  } state_t;

  function automatic logic [1:0] top_lane(input logic [3:0] m);
    if (m[3])      top_lane = 2'd3;
    else if (m[2]) top_lane = 2'd2;
    else if (m[1]) top_lane = 2'd1;
    else           top_lane = 2'd0;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
    case (l)
      2'd3:    lane_byte = d[31:24];
      2'd2:    lane_byte = d[23:16];
      2'd1:    lane_byte = d[15:8];
      default: lane_byte = d[7:0];
    endcase
  endfunction

  function automatic logic [21:0] cmd_adr(input logic [1:0] c, input logic [21:0] prog);
    case (c)
      2'd0:    cmd_adr = 22'h000555;
      2'd1:    cmd_adr = 22'h0002AA;
      2'd2:    cmd_adr = 22'h000555;
      default: cmd_adr = prog;
    endcase
  endfunction

  function automatic logic [7:0] cmd_dat(input logic [1:0] c, input logic [7:0] b);
    case (c)
      2'd0:    cmd_dat = 8'hAA;
      2'd1:    cmd_dat = 8'h55;
      2'd2:    cmd_dat = 8'hA0;
      default: cmd_dat = b;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [15:0] poll_q, poll_d;
  logic [19:0] word_q, word_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  rem_q, rem_d;
  logic        wr_q, wr_d;
  logic        abort_q, abort_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic [21:0] fadr_q, fadr_d;
  logic [7:0]  fdat_q, fdat_d;
  logic        doe_q, doe_d;
  logic        ce_q, ce_d;
  logic        we_q, we_d;
  logic        oe_q, oe_d;

  logic [1:0]  lane_s;
  logic [7:0]  byte_s;
  logic [21:0] prog_adr_s;
  logic [3:0]  rem_next_s;
  logic        unused_s;

  // lane_s is the bit index in sel; its flash byte offset is the bitwise inverse
  assign lane_s     = top_lane(rem_q);
  assign byte_s     = lane_byte(data_q, lane_s);
  assign prog_adr_s = {word_q, ~lane_s};
  assign rem_next_s = rem_q & ~(4'b0001 << lane_s);
  assign unused_s   = ^{wb_adr_i[31:22], wb_adr_i[1:0], flash_dat_i[6:0]};

  // Next-state and next-output logic for the program sequencer
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;    cmd_d = cmd_q;   poll_d = poll_q;
    word_d  = word_q;   data_d = data_q;  rem_d = rem_q;   wr_d = wr_q;
    abort_d = abort_q | ~wb_cyc_i;        err_d = err_q;
    ack_d   = 1'b0;     rdat_d = 32'd0;
    fadr_d  = fadr_q;   fdat_d = fdat_q;  doe_d = doe_q;
    ce_d    = ce_q;     we_d = we_q;      oe_d = oe_q;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (wb_cyc_i && wb_stb_i && !ack_q) begin
          word_d  = wb_adr_i[21:2];
          data_d  = wb_dat_i;
          rem_d   = wb_sel_i;
          wr_d    = wb_we_i;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (!wr_q) begin
          ack_d   = 1'b1;
          rdat_d  = {31'd0, err_q};
          err_d   = 1'b0;
          state_d = S_ACK;
        end else if (rem_q == 4'd0) begin
          ack_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          state_d = S_SETUP;  cmd_d = 2'd0;  poll_d = 16'd0;
          fadr_d  = cmd_adr(2'd0, prog_adr_s);
          fdat_d  = cmd_dat(2'd0, byte_s);
          doe_d   = 1'b1;  ce_d = 1'b0;  we_d = 1'b1;  oe_d = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;  cnt_d = 4'd1;  we_d = 1'b0;
      end
      S_PULSE: begin
        if (cnt_q >= WP_C) begin
          state_d = S_HOLD;  we_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (cmd_q == 2'd3) begin
          state_d = S_POLL;  cnt_d = 4'd1;  fadr_d = prog_adr_s;
          doe_d   = 1'b0;    oe_d = 1'b0;
        end else begin
          state_d = S_SETUP;  cmd_d = cmd_q + 2'd1;
          fadr_d  = cmd_adr(cmd_q + 2'd1, prog_adr_s);
          fdat_d  = cmd_dat(cmd_q + 2'd1, byte_s);
        end
      end
      S_POLL: begin
        if (cnt_q < PS_C) begin
          cnt_d = cnt_q + 4'd1;
        end else if (flash_dat_i[7] == byte_s[7]) begin
          rem_d  = rem_next_s;
          poll_d = 16'd0;
          if (abort_d) begin
            state_d = S_IDLE;  ce_d = 1'b1;  oe_d = 1'b1;
          end else if (rem_next_s == 4'd0) begin
            state_d = S_ACK;   ack_d = 1'b1;  ce_d = 1'b1;  oe_d = 1'b1;
          end else begin
            state_d = S_SETUP;  cmd_d = 2'd0;
            fadr_d  = cmd_adr(2'd0, prog_adr_s);
            fdat_d  = cmd_dat(2'd0, byte_s);
            doe_d   = 1'b1;  oe_d = 1'b1;
          end
        end else if (poll_q + 16'd1 >= TO) begin
          err_d = 1'b1;  rem_d = 4'd0;  ce_d = 1'b1;  oe_d = 1'b1;
          if (abort_d) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ACK;  ack_d = 1'b1;
          end
        end else begin
          poll_d  = poll_q + 16'd1;
          state_d = S_GAP;  oe_d = 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_POLL;  cnt_d = 4'd1;  oe_d = 1'b0;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        doe_d = 1'b0;  ce_d = 1'b1;  we_d = 1'b1;  oe_d = 1'b1;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;  cnt_q <= 4'd0;    cmd_q <= 2'd0;   poll_q <= 16'd0;
      word_q  <= 20'd0;   data_q <= 32'd0;  rem_q <= 4'd0;   wr_q <= 1'b0;
      abort_q <= 1'b0;    err_q <= 1'b0;    ack_q <= 1'b0;   rdat_q <= 32'd0;
      fadr_q  <= 22'd0;   fdat_q <= 8'd0;   doe_q <= 1'b0;
      ce_q    <= 1'b1;    we_q <= 1'b1;     oe_q <= 1'b1;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;   cmd_q <= cmd_d;  poll_q <= poll_d;
      word_q  <= word_d;  data_q <= data_d; rem_q <= rem_d;  wr_q <= wr_d;
      abort_q <= abort_d; err_q <= err_d;   ack_q <= ack_d;  rdat_q <= rdat_d;
      fadr_q  <= fadr_d;  fdat_q <= fdat_d; doe_q <= doe_d;
      ce_q    <= ce_d;    we_q <= we_d;     oe_q <= oe_d;
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = rdat_q;
  assign flash_adr_o  = fadr_q;
  assign flash_dat_o  = fdat_q;
  assign flash_dat_oe = doe_q;
  assign flash_ce     = ce_q;
  assign flash_we     = we_q;
  assign flash_oe     = oe_q;
  assign flash_rst    = ~wb_rst_i;
endmodule

// File: tb/tb_flash_prog.sv
// tb_flash_prog: directed bench for flash_prog with a DQ7-polling flash model
// that records every command bus cycle.
module tb_flash_prog;
  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [31:0] wb_adr_i = 32'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = 4'd0;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic [21:0] flash_adr_o;
  logic [7:0]  flash_dat_o;
  logic [7:0]  flash_dat_i;
  logic        flash_dat_oe, flash_ce, flash_we, flash_oe, flash_rst;

  always #5 clk = ~clk;

  flash_prog #(.WP(3), .PS(3), .TO(16'd5)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .flash_adr_o(flash_adr_o),
    .flash_dat_o(flash_dat_o), .flash_dat_i(flash_dat_i), .flash_dat_oe(flash_dat_oe),
    .flash_ce(flash_ce), .flash_we(flash_we), .flash_oe(flash_oe), .flash_rst(flash_rst)
  );

  // flash model: busy[offset] failed polls before DQ7 shows the true bit
  logic [21:0] log_adr[$];
  logic [7:0]  log_dat[$];
  int          busy[4] = '{0, 0, 0, 0};
  int          fails = 0;
  logic [1:0]  cur_off = 2'd0;
  logic        cur_bit = 1'b0;
  logic        prev_we = 1'b1, prev_oe = 1'b1;
  int          pulse = 0, bad_pulse = 0, clash = 0, ce_low_cnt = 0;

  assign flash_dat_i = {((fails >= busy[cur_off]) ? cur_bit : ~cur_bit), 7'd0};

  always @(negedge clk) begin
    if (!flash_we && prev_we) begin
      log_adr.push_back(flash_adr_o);
      log_dat.push_back(flash_dat_o);
      pulse <= 1;
      if (log_adr.size() % 4 == 0) begin
        cur_off <= flash_adr_o[1:0];
        cur_bit <= flash_dat_o[7];
        fails   <= 0;
      end
    end else if (!flash_we) begin
      pulse <= pulse + 1;
    end
    if (flash_we && !prev_we && pulse != 3) bad_pulse <= bad_pulse + 1;
    if (flash_oe && !prev_oe && !flash_ce) fails <= fails + 1;
    if (flash_dat_oe && !flash_oe) clash <= clash + 1;
    if (!flash_ce) ce_low_cnt <= ce_low_cnt + 1;
    prev_we <= flash_we;
    prev_oe <= flash_oe;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int edges, output logic [31:0] rdata);
    @(negedge clk);
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    edges = -1; rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        edges = k; rdata = wb_dat_o;
        break;
      end
    end
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  int          e, base, ce0, acks;
  logic [31:0] rd;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    check("rst_adr", 32'(flash_adr_o), 32'd0);
    check("rst_fdat", 32'(flash_dat_o), 32'd0);
    check("rst_dat_oe", 32'(flash_dat_oe), 32'd0);
    check("rst_ce", 32'(flash_ce), 32'd1);
    check("rst_we", 32'(flash_we), 32'd1);
    check("rst_oe", 32'(flash_oe), 32'd1);
    check("rst_flash_rst", 32'(flash_rst), 32'd0);
    @(negedge clk); wb_rst_i = 1'b0;
    #1;
    check("flash_rst_run", 32'(flash_rst), 32'd1);

    // single lane, flash ready immediately
    base = log_adr.size();
    access(1'b1, 32'h0000_1234, 32'hA5C3_1E7F, 4'b1000, e, rd);
    check("one_lane_ack_edge", 32'(e), 32'd24);
    check("one_lane_ncmd", 32'(log_adr.size() - base), 32'd4);
    check("c0_adr", 32'(log_adr[base]),   32'h555);  check("c0_dat", 32'(log_dat[base]),   32'hAA);
    check("c1_adr", 32'(log_adr[base+1]), 32'h2AA);  check("c1_dat", 32'(log_dat[base+1]), 32'h55);
    check("c2_adr", 32'(log_adr[base+2]), 32'h555);  check("c2_dat", 32'(log_dat[base+2]), 32'hA0);
    check("c3_adr", 32'(log_adr[base+3]), 32'h1234); check("c3_dat", 32'(log_dat[base+3]), 32'hA5);
    check("we_pulse_width", 32'(bad_pulse), 32'd0);

    // four lanes, lane offset 0 busy for two polls
    busy[0] = 2;
    base = log_adr.size();
    access(1'b1, 32'h0000_1234, 32'hA5C3_1E7F, 4'b1111, e, rd);
    check("four_lane_ack_edge", 32'(e), 32'd101);
    check("four_lane_ncmd", 32'(log_adr.size() - base), 32'd16);
    check("l0_adr", 32'(log_adr[base+3]),  32'h1234); check("l0_dat", 32'(log_dat[base+3]),  32'hA5);
    check("l1_adr", 32'(log_adr[base+7]),  32'h1235); check("l1_dat", 32'(log_dat[base+7]),  32'hC3);
    check("l2_adr", 32'(log_adr[base+11]), 32'h1236); check("l2_dat", 32'(log_dat[base+11]), 32'h1E);
    check("l3_adr", 32'(log_adr[base+15]), 32'h1237); check("l3_dat", 32'(log_dat[base+15]), 32'h7F);
    check("l1_unlock", 32'(log_dat[base+4]), 32'hAA);

    // timeout on lane offset 1 (TO = 5)
    busy[0] = 0; busy[1] = 1000;
    base = log_adr.size();
    access(1'b1, 32'h0000_1234, 32'hA5C3_1E7F, 4'b1111, e, rd);
    check("timeout_ack_edge", 32'(e), 32'd63);
    check("timeout_ncmd", 32'(log_adr.size() - base), 32'd8);
    check("timeout_gaps", 32'(fails), 32'd4);
    access(1'b0, 32'h0, 32'h0, 4'b1111, e, rd);
    check("err_read_edge", 32'(e), 32'd1);
    check("err_read_dat", rd, 32'h1);
    access(1'b0, 32'h0, 32'h0, 4'b1111, e, rd);
    check("err_cleared", rd, 32'h0);
    busy[1] = 0;

    // cyc drops during lane offset 0's first command
    base = log_adr.size();
    @(negedge clk);
    wb_we_i = 1'b1; wb_adr_i = 32'h0000_1234; wb_dat_i = 32'hA5C3_1E7F; wb_sel_i = 4'b1111;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    acks = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (wb_ack_o) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_ncmd", 32'(log_adr.size() - base), 32'd4);
    check("abort_prog_adr", 32'(log_adr[base+3]), 32'h1234);
    check("abort_idle_ce", 32'(flash_ce), 32'd1);

    // sel = 0 write, then status read
    ce0 = ce_low_cnt;
    access(1'b1, 32'h0000_1234, 32'hA5C3_1E7F, 4'b0000, e, rd);
    check("sel0_ack_edge", 32'(e), 32'd1);
    check("sel0_ce_idle", 32'(ce_low_cnt - ce0), 32'd0);
    access(1'b0, 32'h0, 32'h0, 4'b0000, e, rd);
    check("status_ack_edge", 32'(e), 32'd1);
    check("status_dat", rd, 32'h0);
    check("oe_dat_oe_clash", 32'(clash), 32'd0);
    check("we_pulse_all", 32'(bad_pulse), 32'd0);

    // reset in the middle of lane offset 1's first write pulse
    @(negedge clk);
    wb_we_i = 1'b1; wb_adr_i = 32'h0000_1234; wb_dat_i = 32'hA5C3_1E7F; wb_sel_i = 4'b1111;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (26) @(posedge clk);
    #1;
    check("lane2_pulse_we", 32'(flash_we), 32'd0);
    @(negedge clk); wb_rst_i = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_we", 32'(flash_we), 32'd1);
    check("rst_mid_ce", 32'(flash_ce), 32'd1);
    check("rst_mid_dat_oe", 32'(flash_dat_oe), 32'd0);
    check("rst_mid_ack", 32'(wb_ack_o), 32'd0);
    @(negedge clk);
    wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    access(1'b0, 32'h0, 32'h0, 4'b1111, e, rd);
    check("post_rst_read_edge", 32'(e), 32'd1);
    check("post_rst_read_dat", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_prog.md
# flash_prog

Wishbone B3 classic slave that programs the parallel NOR flash. Each Wishbone write runs an AMD-style byte-program command sequence and a DQ7 data poll for every selected byte lane. Reads return a sticky error status. It is the write-side companion to the read-only flash interface and shares its flash pins through the board-level mux, which is selected by address decode.

## Interface
Parameters:
- `WP`, default 3: `flash_we` low-pulse width, in clocks (1..15).
- `PS`, default 3: data-poll read access time, in clocks (1..15).
- `TO`, default 16'd4000: maximum number of poll reads per byte before timeout.

Ports:
- `wb_clk_i`, in, 1: the only clock. Every register updates on its rising edge.
- `wb_rst_i`, in, 1: synchronous, active-high reset (`RstEnable`).
- `wb_adr_i`, in, 32: byte address. Bits [21:2] select the flash word.
- `wb_dat_i`, in, 32: write data, big-endian. `[31:24]` goes to lane offset 0.
- `wb_dat_o`, out, 32: read data, `{31'b0, err}`.
- `wb_sel_i`, in, 4: lane enables. `sel[3]` is offset 0 and `sel[0]` is offset 3.
- `wb_we_i`, `wb_stb_i`, `wb_cyc_i`, in, 1 each: standard Wishbone controls.
- `wb_ack_o`, out, 1: single-cycle acknowledge.
- `flash_adr_o`, out, 22: flash byte address.
- `flash_dat_o`, out, 8: data driven to the flash.
- `flash_dat_i`, in, 8: data read from the flash.
- `flash_dat_oe`, out, 1: tristate enable. 1 means the block drives the flash bus.
- `flash_ce`, `flash_we`, `flash_oe`, out, 1 each: active-low strobes.
- `flash_rst`, out, 1: active-low flash reset, equal to `!wb_rst_i`.

## Operation
Access acceptance:
- An access is accepted in IDLE when `wb_cyc_i & wb_stb_i & !wb_ack_o`.

Read access:
- Ack 1 cycle after acceptance, with `wb_dat_o = {31'b0, err}`.
- The same edge clears `err`.
- The flash is untouched.

Write access with `wb_sel_i == 0`:
- Ack 1 cycle after acceptance.
- No flash activity.

Write access with lanes selected:
- The block latches the address, data and sel, then processes the selected lanes in order `sel[3]` → `sel[0]`.

Per lane, four command bus cycles:
- (22'h555, 8'hAA)
- (22'h2AA, 8'h55)
- (22'h555, 8'hA0)
- ({adr[21:2], lane_offset}, lane_byte)

Each bus cycle has three phases:
- SETUP, 1 clock: address and data valid, `dat_oe=1`, `ce=0`, `we=1`.
- PULSE, `WP` clocks: `we=0`.
- HOLD, 1 clock: `we=1`, address and data still held.

Poll, after the four command cycles:
- `dat_oe=0`, `oe=0`, `ce=0`, address set to the programmed byte.
- `flash_dat_i[7]` is sampled on the `PS`-th clock.
- If it equals `lane_byte[7]`, the lane is done.
- Otherwise `oe=1` for 1 clock (GAP), the poll counter increments, and the poll repeats.
- When the counter reaches `TO` without a match, set `err=1`, skip all remaining lanes and proceed to ACK.

States: IDLE → CMD(SETUP/PULSE/HOLD, ×4) → POLL ⇄ GAP → next lane or ACK → IDLE.

ACK state:
- `wb_ack_o=1` for exactly one clock.
- `ce=oe=we=1`, `dat_oe=0`.

Cycle abort:
- If `wb_cyc_i` drops mid-write, the current lane's sequence and poll run to completion (the flash command cannot be cancelled).
- Remaining lanes are skipped.
- Return to IDLE with no ack.

Reset:
- Reset during any state returns to IDLE within one edge.
- All outputs take their reset values.
- `err` clears.
- `flash_dat_oe` must never be 1 while `flash_oe` is 0.

## Timing
Reset values:
- `wb_ack_o=0`, `wb_dat_o=0`
- `flash_adr_o=0`, `flash_dat_o=0`, `flash_dat_oe=0`
- `flash_ce=1`, `flash_we=1`, `flash_oe=1`

Latency, with acceptance at edge 0 and the flash ready on the first poll:
- One lane: ack high at edge `4*(WP+2)+PS+1` (24 with defaults).
- Each further lane adds `4*(WP+2)+PS` (23).
- Each failed poll adds `PS+1`.

Bus-cycle shape:
- Address and data are stable from SETUP through HOLD.
- `ce` stays low continuously from the first SETUP to the end of the last POLL.
- `we` is never low in POLL or GAP.

Between lanes:
- No idle clock; the next lane's SETUP directly follows the previous lane's final POLL.

Ack timing:
- `wb_ack_o` is registered and is high for one clock only.
- A new access is accepted no earlier than the clock after the ack.

## Test plan
- Reset mid-PULSE of lane 2 → next edge: `we=1`, `ce=1`, `dat_oe=0`, `ack=0`, state IDLE; a read then returns 0.
- Write `adr=0x00001234`, `dat=0xA5C3_1E7F`, `sel=4'b1000`, with the flash model ready immediately → command cycles 555/AA, 2AA/55, 555/A0, 001234/A5, each with a 3-clock `we` pulse; ack at edge 24; `flash_adr_o` never drives offsets 1–3.
- Same data with `sel=4'b1111`, model busy for 2 polls on lane 0 → bytes A5, C3, 1E, 7F programmed to 001234..001237 in that order; ack at edge 24+3·23+2·4=101.
- Model never matches DQ7 on lane `sel[2]` with `TO=5` → 5 polls, then ack with no lane-1/0 sequences; a following read returns 0x00000001 and a second read returns 0.
- `cyc` drops during lane 3's first command → lane 3 completes its sequence and poll, no ack, lanes 2–0 are never issued, IDLE.
- Write with `sel=0` → ack at edge 1 and `flash_ce` stays 1; a read of status → ack at edge 1.
